// File: rtl/ldst_burst_fsm_if.sv
// Bus between the load/store burst sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath.
interface ldst_burst_fsm_if #(
  parameter int unsigned BLW = 3
);
  logic           LDSRstr;
  logic [3:0]     opCode;
  logic [BLW-1:0] burstLen;
  logic           MFC;
  logic           DIRiEn;
  logic           DIRjEn;
  logic           RrEn;
  logic           RwEn;
  logic           MARload;
  logic           MARinc;
  logic           regInc;
  logic           MDRwriteEn;
  logic           MDRreadEn;
  logic           MDRrOutEn;
  logic           MEMEn;
  logic           MEMR_W;
  logic           IF;
  logic           busy;
  logic           err;
  logic [BLW-1:0] wordCnt;

  modport master (
    input  LDSRstr, opCode, burstLen, MFC,
    output DIRiEn, DIRjEn, RrEn, RwEn, MARload, MARinc, regInc,
           MDRwriteEn, MDRreadEn, MDRrOutEn, MEMEn, MEMR_W, IF, busy, err, wordCnt
  );

  modport slave (
    output LDSRstr, opCode, burstLen, MFC,
    input  DIRiEn, DIRjEn, RrEn, RwEn, MARload, MARinc, regInc,
           MDRwriteEn, MDRreadEn, MDRrOutEn, MEMEn, MEMR_W, IF, busy, err, wordCnt
  );
endinterface

// File: rtl/ldst_burst_fsm.sv
// Moore sequencer for LOAD/STORE bursts of 1..MAX_BURST words with an MFC timeout.
// Outputs are registered from the decode of the next state, so they track the state register.
module ldst_burst_fsm #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned BLW       = 3
) (
  input  logic             clk,
  input  logic             reset,
  ldst_burst_fsm_if.master bus
);
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam int unsigned OW       = 15;
  localparam logic [3:0]  OP_LOAD  = 4'b1011;
  localparam logic [3:0]  OP_STORE = 4'b1100;

  localparam int unsigned B_DIRI = 14, B_DIRJ = 13, B_RR = 12, B_RW = 11, B_MARLD = 10;
  localparam int unsigned B_MARINC = 9, B_REGINC = 8, B_MDRWR = 7, B_MDRRD = 6, B_MDROUT = 5;
  localparam int unsigned B_MEMEN = 4, B_MEMRW = 3, B_IF = 2, B_BUSY = 1, B_ERR = 0;

  typedef enum logic [3:0] {
    IDLE, DECODE, ADDR, RDREG, MEM_WR, MEM_RD, LATCH, WB, NEXT, DONE, ERR
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [BLW-1:0] len_q, len_d;
  logic [BLW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [OW-1:0]  out_q;
  logic           last_c;
  logic           is_load_c;
  logic           tmo_hit_c;

  assign last_c    = (cnt_q == len_q - BLW'(1));
  assign is_load_c = (op_q == OP_LOAD);
  assign tmo_hit_c = (tmo_q == TW'(TIMEOUT - 1));

  function automatic logic [OW-1:0] decode(input state_e s);
    logic [OW-1:0] o;
    o = '0;
    o[B_BUSY] = (s != IDLE);
    case (s)
      ADDR:   begin o[B_DIRI] = 1'b1; o[B_RR] = 1'b1; o[B_MARLD] = 1'b1; end
      RDREG:  begin o[B_DIRJ] = 1'b1; o[B_RR] = 1'b1; o[B_MDRWR] = 1'b1; end
      MEM_WR: o[B_MEMEN] = 1'b1;
      MEM_RD: begin o[B_MEMEN] = 1'b1; o[B_MEMRW] = 1'b1; end
      LATCH:  o[B_MDRRD] = 1'b1;
      WB:     begin o[B_MDROUT] = 1'b1; o[B_DIRJ] = 1'b1; o[B_RW] = 1'b1; end
      NEXT:   begin o[B_MARINC] = 1'b1; o[B_REGINC] = 1'b1; end
      DONE:   o[B_IF] = 1'b1;
      ERR:    begin o[B_IF] = 1'b1; o[B_ERR] = 1'b1; end
      default: o = o;
    endcase
    return o;
  endfunction

  // Next-state logic; the timeout counter is zero unless it is counting inside a wait state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: if (bus.LDSRstr) begin
        op_d    = bus.opCode;
        len_d   = bus.burstLen;
        state_d = DECODE;
      end
      DECODE: begin
        cnt_d = '0;
        if (len_q == '0)                   len_d = BLW'(1);
        else if (len_q > BLW'(MAX_BURST))  len_d = BLW'(MAX_BURST);
        state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? ADDR : ERR;
      end
      ADDR:   state_d = is_load_c ? MEM_RD : RDREG;
      RDREG:  state_d = MEM_WR;
      MEM_WR, MEM_RD: begin
        if (bus.MFC) begin
          if (state_q == MEM_RD) state_d = LATCH;
          else                   state_d = last_c ? DONE : NEXT;
        end else if (tmo_hit_c) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      LATCH:  state_d = WB;
      WB:     state_d = last_c ? DONE : NEXT;
      NEXT: begin
        cnt_d   = cnt_q + BLW'(1);
        state_d = is_load_c ? MEM_RD : RDREG;
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      out_q   <= decode(state_d);
    end
  end

  assign bus.DIRiEn     = out_q[B_DIRI];
  assign bus.DIRjEn     = out_q[B_DIRJ];
  assign bus.RrEn       = out_q[B_RR];
  assign bus.RwEn       = out_q[B_RW];
  assign bus.MARload    = out_q[B_MARLD];
  assign bus.MARinc     = out_q[B_MARINC];
  assign bus.regInc     = out_q[B_REGINC];
  assign bus.MDRwriteEn = out_q[B_MDRWR];
  assign bus.MDRreadEn  = out_q[B_MDRRD];
  assign bus.MDRrOutEn  = out_q[B_MDROUT];
  assign bus.MEMEn      = out_q[B_MEMEN];
  assign bus.MEMR_W     = out_q[B_MEMRW];
  assign bus.IF         = out_q[B_IF];
  assign bus.busy       = out_q[B_BUSY];
  assign bus.err        = out_q[B_ERR];
  assign bus.wordCnt    = cnt_q;
endmodule

// File: tb/tb_ldst_burst_fsm.sv
// Directed bench for ldst_burst_fsm: runs whole transfers and checks per-cycle
// output patterns and event counts against hand-computed values.
module tb_ldst_burst_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldst_burst_fsm_if #(.BLW(3)) bus ();
  ldst_burst_fsm #(.MAX_BURST(4), .TIMEOUT(16), .BLW(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {DIRiEn,DIRjEn,RrEn,RwEn,MARload,MARinc,regInc,MDRwriteEn,MDRreadEn,MDRrOutEn,MEMEn,MEMR_W,IF,busy,err}
  function automatic logic [14:0] sig();
    return {bus.DIRiEn, bus.DIRjEn, bus.RrEn, bus.RwEn, bus.MARload, bus.MARinc, bus.regInc,
            bus.MDRwriteEn, bus.MDRreadEn, bus.MDRrOutEn, bus.MEMEn, bus.MEMR_W,
            bus.IF, bus.busy, bus.err};
  endfunction

  logic [14:0] r_sig [0:15];
  int          r_cyc_if, r_cyc_err, r_memen, r_memwr, r_marinc, r_reginc, r_if, r_err;
  int          r_marload, r_rwen, r_mdrrd, r_words;
  logic [7:0]  r_mask;
  logic        r_done, r_busy1, r_busy2;
  logic [14:0] r_rst_sig;
  logic [2:0]  r_rst_wc;

  task automatic run_xfer(input logic [3:0] op, input logic [2:0] len, input int delay,
                          input bit hold, input int rst_word);
    int wait_c = 0;
    bit prev_me = 1'b0;
    r_cyc_if = 0; r_cyc_err = 0; r_memen = 0; r_memwr = 0; r_marinc = 0; r_reginc = 0;
    r_if = 0; r_err = 0; r_marload = 0; r_rwen = 0; r_mdrrd = 0; r_words = 0;
    r_mask = '0; r_done = 1'b0; r_busy1 = 1'bx; r_busy2 = 1'bx;
    for (int i = 0; i < 16; i++) r_sig[i] = '1;
    bus.LDSRstr = 1'b1; bus.opCode = op; bus.burstLen = len; bus.MFC = 1'b0;
    for (int cyc = 1; cyc <= 200 && !r_done; cyc++) begin
      @(posedge clk); #1;
      if (!hold) bus.LDSRstr = 1'b0;
      if (cyc < 16) r_sig[cyc[3:0]] = sig();
      if (bus.MEMEn) begin
        r_memen++;
        if (!bus.MEMR_W) r_memwr++;
        if (!prev_me) begin r_words++; r_mask[bus.wordCnt] = 1'b1; end
      end
      prev_me = bus.MEMEn;
      if (bus.MARinc)    r_marinc++;
      if (bus.regInc)    r_reginc++;
      if (bus.MARload)   r_marload++;
      if (bus.RwEn)      r_rwen++;
      if (bus.MDRreadEn) r_mdrrd++;
      if (bus.err) begin r_err++; r_cyc_err = cyc; end
      if (bus.IF)  begin r_if++;  r_cyc_if = cyc; r_done = 1'b1; end
      if (rst_word >= 0 && bus.MEMEn && int'(bus.wordCnt) == rst_word) begin
        reset = 1'b1; bus.MFC = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.MFC = 1'b0;
        r_rst_sig = sig(); r_rst_wc = bus.wordCnt; r_done = 1'b1;
      end else if (bus.MEMEn) begin
        bus.MFC = (wait_c >= delay); wait_c++;
      end else begin
        bus.MFC = 1'b0; wait_c = 0;
      end
    end
    bus.LDSRstr = 1'b0; bus.MFC = 1'b0;
    @(posedge clk); #1; r_busy1 = bus.busy;
    @(posedge clk); #1; r_busy2 = bus.busy;
  endtask

  initial begin
    bus.LDSRstr = 1'b1; bus.opCode = 4'b1011; bus.burstLen = 3'd1; bus.MFC = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'(sig()), 32'h0);
    check("rst_wordcnt", 32'(bus.wordCnt), 32'h0);
    reset = 1'b0; bus.LDSRstr = 1'b0; bus.MFC = 1'b0;
    @(posedge clk); #1;

    run_xfer(4'b1011, 3'd1, 0, 1'b0, -1);
    check("ld1_done", 32'(r_done), 1);
    check("ld1_c1_decode", 32'(r_sig[1]), 32'h0002);
    check("ld1_c2_addr",   32'(r_sig[2]), 32'h5402);
    check("ld1_c3_memrd",  32'(r_sig[3]), 32'h001A);
    check("ld1_c4_latch",  32'(r_sig[4]), 32'h0042);
    check("ld1_c5_wb",     32'(r_sig[5]), 32'h2822);
    check("ld1_c6_done",   32'(r_sig[6]), 32'h0006);
    check("ld1_if_cycle",  32'(r_cyc_if), 6);
    check("ld1_marinc",    32'(r_marinc), 0);
    check("ld1_busy_after", 32'(r_busy1), 0);

    run_xfer(4'b1100, 3'd1, 0, 1'b0, -1);
    check("st1_c3_rdreg", 32'(r_sig[3]), 32'h3082);
    check("st1_c4_memwr", 32'(r_sig[4]), 32'h0012);
    check("st1_if_cycle", 32'(r_cyc_if), 5);

    run_xfer(4'b1100, 3'd3, 2, 1'b1, -1);
    check("st3_done", 32'(r_done), 1);
    check("st3_words", 32'(r_words), 3);
    check("st3_memwr_cycles", 32'(r_memwr), 9);
    check("st3_marinc", 32'(r_marinc), 2);
    check("st3_reginc", 32'(r_reginc), 2);
    check("st3_wc_seen", 32'(r_mask), 32'h7);
    check("st3_if_count", 32'(r_if), 1);
    check("st3_if_cycle", 32'(r_cyc_if), 17);
    check("st3_busy_after", 32'(r_busy1), 0);
    check("st3_no_requeue", 32'(r_busy2), 0);

    run_xfer(4'b0101, 3'd1, 0, 1'b0, -1);
    check("ill_c2_err", 32'(r_sig[2]), 32'h0007);
    check("ill_if_cycle", 32'(r_cyc_if), 2);
    check("ill_err_cycle", 32'(r_cyc_err), 2);
    check("ill_memen", 32'(r_memen), 0);
    check("ill_marload", 32'(r_marload), 0);
    check("ill_rwen", 32'(r_rwen), 0);

    run_xfer(4'b1011, 3'd1, 1000, 1'b0, -1);
    check("tmo_memen_cycles", 32'(r_memen), 16);
    check("tmo_err", 32'(r_err), 1);
    check("tmo_if_cycle", 32'(r_cyc_if), 19);
    check("tmo_latch", 32'(r_mdrrd), 0);
    check("tmo_busy_after", 32'(r_busy1), 0);

    run_xfer(4'b1011, 3'd1, 15, 1'b0, -1);
    check("tmo16_memen_cycles", 32'(r_memen), 16);
    check("tmo16_err", 32'(r_err), 0);
    check("tmo16_latch", 32'(r_mdrrd), 1);
    check("tmo16_if_cycle", 32'(r_cyc_if), 21);

    run_xfer(4'b1011, 3'd0, 0, 1'b0, -1);
    check("len0_words", 32'(r_words), 1);
    check("len0_if_cycle", 32'(r_cyc_if), 6);

    run_xfer(4'b1100, 3'd7, 0, 1'b0, -1);
    check("len7_words", 32'(r_words), 4);
    check("len7_marinc", 32'(r_marinc), 3);
    check("len7_wc_seen", 32'(r_mask), 32'hF);
    check("len7_if_cycle", 32'(r_cyc_if), 14);

    run_xfer(4'b1011, 3'd3, 2, 1'b0, 1);
    check("rstmid_reached", 32'(r_done), 1);
    check("rstmid_outputs", 32'(r_rst_sig), 32'h0);
    check("rstmid_wordcnt", 32'(r_rst_wc), 0);
    check("rstmid_no_resume", 32'(r_busy2), 0);

    run_xfer(4'b1011, 3'd1, 0, 1'b0, -1);
    check("post_rst_wc_seen", 32'(r_mask), 32'h1);
    check("post_rst_if_cycle", 32'(r_cyc_if), 6);
    check("post_rst_err", 32'(r_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
